// File: rtl/oram_traffic_checker.sv
// Traffic generator/checker for the PathORamTop frontend: issues Update/Read commands, checks read beats against a shadow.
// Optional ORAM_TG_READRMV_EN: existing blocks may be read with ReadRmv (LFSR bit 0), which retires the shadow entry.
module oram_traffic_checker #(
  parameter int unsigned ORAMU         = 32,
  parameter int unsigned ORAMB         = 512,
  parameter int unsigned FEDWidth      = 32,
  parameter int unsigned NumBlocks     = 256,
  parameter int unsigned NumAccesses   = 600,
  parameter int unsigned Stride        = 16,
  parameter int unsigned GapCycles     = 100,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [1:0]          Mode,
  output logic [1:0]          Cmd,
  output logic [ORAMU-1:0]    PAddr,
  output logic                CmdValid,
  input  logic                CmdReady,
  output logic [FEDWidth-1:0] DataIn,
  output logic                DataInValid,
  input  logic                DataInReady,
  input  logic [FEDWidth-1:0] DataOut,
  input  logic                DataOutValid,
  output logic                DataOutReady,
  output logic                Busy,
  output logic                Done,
  output logic                Pass,
  output logic                Timeout,
  output logic [15:0]         ErrorCount,
  output logic [ORAMU-1:0]    FirstErrAddr
);

  localparam int unsigned Chunks = ORAMB / FEDWidth;
  localparam int unsigned AW     = (NumBlocks > 1) ? $clog2(NumBlocks) : 1;
  localparam int unsigned CW     = (Chunks > 1) ? $clog2(Chunks) : 1;

  localparam logic [31:0]   HalfAcc  = 32'(NumAccesses / 2);
  localparam logic [31:0]   AccTotal = 32'(NumAccesses);
  localparam logic [31:0]   LastBlk  = 32'(NumBlocks - 1);
  localparam logic [31:0]   GapLast  = 32'(GapCycles) - 32'd1;
  localparam logic [31:0]   WaitLast = 32'(TimeoutCycles) - 32'd1;
  localparam logic [CW-1:0] BeatLast = CW'(Chunks - 1);
  localparam bit            GapZero  = (GapCycles == 0);

  localparam logic [1:0] OpUpdate  = 2'd0;
  localparam logic [1:0] OpRead    = 2'd2;
  localparam logic [1:0] OpReadRmv = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_CMD   = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [1:0]          mode_q;
  logic [AW-1:0]       addr_q;
  logic [31:0]         acc_q, cnt_q, wait_q, lfsr_q, lfsr_nxt;
  logic [CW-1:0]       beat_q;
  logic [FEDWidth-1:0] seed_q, beat_val;
  logic [1:0]          cmd_q, op_c;
  logic [15:0]         err_q, err_sat;
  logic [16:0]         err_sum;
  logic [ORAMU-1:0]    first_q;
  logic                seen_q, timeout_q, done_q, busy_q;

  logic [NumBlocks-1:0] exist_q;
  logic [FEDWidth-1:0]  seed_mem [NumBlocks];

  logic cmd_fire, win_fire, rout_fire, beat_fire, waiting, tmo, last_beat, mism, spur;
  logic [1:0] err_inc;

  function automatic logic [AW-1:0] gen_addr(input logic [1:0] m, input logic [31:0] i,
                                             input logic [31:0] lf);
    logic [31:0] t;
    case (m)
      2'd0:    t = i;
      2'd1:    t = i * 32'(Stride);
      2'd2:    t = lf;
      default: t = (i < HalfAcc) ? i : (i - HalfAcc) * 32'(Stride);
    endcase
    return t[AW-1:0];
  endfunction

  assign lfsr_nxt = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign beat_val = seed_q + FEDWidth'(beat_q);

  always_comb begin
    op_c = OpUpdate;
    if (exist_q[addr_q]) begin
`ifdef ORAM_TG_READRMV_EN
      op_c = lfsr_q[0] ? OpReadRmv : OpRead;
`else
      op_c = OpRead;
`endif
    end
  end

  always_comb begin
    cmd_fire  = (state_q == S_CMD) && CmdReady;
    win_fire  = (state_q == S_WDATA) && DataInReady;
    rout_fire = (state_q == S_RDATA) && DataOutValid;
    beat_fire = win_fire || rout_fire;
    waiting   = (state_q == S_CMD) || (state_q == S_WDATA) || (state_q == S_RDATA);
    tmo       = waiting && !(cmd_fire || beat_fire) && (wait_q == WaitLast);
    last_beat = (beat_q == BeatLast);
    mism      = rout_fire && (DataOut != beat_val);
    spur      = DataOutValid && (state_q != S_RDATA);
    err_inc   = 2'({1'b0, mism}) + 2'({1'b0, spur}) + 2'({1'b0, tmo});
    err_sum   = {1'b0, err_q} + 17'(err_inc);
    err_sat   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (Start) state_d = S_CLEAR;
      S_CLEAR: if (cnt_q == LastBlk) state_d = GapZero ? S_CMD : S_GAP;
      S_GAP:   if (GapZero || cnt_q == GapLast) state_d = S_CMD;
      S_CMD: begin
        if (tmo)           state_d = S_DONE;
        else if (cmd_fire) state_d = (op_c == OpUpdate) ? S_WDATA : S_RDATA;
      end
      S_WDATA, S_RDATA: begin
        if (tmo)                         state_d = S_DONE;
        else if (beat_fire && last_beat) state_d = S_NEXT;
      end
      S_NEXT: state_d = (acc_q + 32'd1 == AccTotal) ? S_DONE : (GapZero ? S_CMD : S_GAP);
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      addr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      lfsr_q    <= 32'hACE1_0001;
      beat_q    <= '0;
      seed_q    <= '0;
      cmd_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= (waiting && !(cmd_fire || beat_fire)) ? wait_q + 32'd1 : '0;
      if (err_inc != 2'd0) begin
        err_q <= err_sat;
        if (!seen_q) begin
          seen_q  <= 1'b1;
          first_q <= ORAMU'(addr_q);
        end
      end
      if (tmo) begin
        timeout_q <= 1'b1;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
      end
      // Start handling sits after error accounting so a new run begins with clean flags.
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            mode_q    <= Mode;
            addr_q    <= gen_addr(Mode, 32'd0, lfsr_q);
            acc_q     <= '0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            err_q     <= '0;
            first_q   <= '0;
            seen_q    <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_CLEAR: cnt_q <= (cnt_q == LastBlk) ? '0 : cnt_q + 32'd1;
        S_GAP:   cnt_q <= (state_d == S_CMD) ? '0 : cnt_q + 32'd1;
        S_CMD: begin
          if (cmd_fire) begin
            cmd_q  <= op_c;
            seed_q <= (op_c == OpUpdate) ? lfsr_q : seed_mem[addr_q];
            beat_q <= '0;
          end
        end
        S_WDATA, S_RDATA: if (beat_fire) beat_q <= beat_q + 1'b1;
        S_NEXT: begin
          acc_q  <= acc_q + 32'd1;
          lfsr_q <= lfsr_nxt;
          addr_q <= gen_addr(mode_q, acc_q + 32'd1, lfsr_nxt);
          cnt_q  <= '0;
          if (state_d == S_DONE) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow is deliberately outside the reset domain; only CLEAR wipes it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (state_q == S_CLEAR) exist_q[cnt_q[AW-1:0]] <= 1'b0;
      if (win_fire && last_beat) begin
        exist_q[addr_q]  <= 1'b1;
        seed_mem[addr_q] <= seed_q;
      end
`ifdef ORAM_TG_READRMV_EN
      if (rout_fire && last_beat && cmd_q == OpReadRmv) exist_q[addr_q] <= 1'b0;
`endif
    end
  end

  assign Cmd          = (state_q == S_CMD) ? op_c : cmd_q;
  assign PAddr        = ORAMU'(addr_q);
  assign CmdValid     = (state_q == S_CMD);
  assign DataIn       = beat_val;
  assign DataInValid  = (state_q == S_WDATA);
  assign DataOutReady = (state_q == S_RDATA);
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Pass         = done_q && (err_q == 16'd0) && !timeout_q;
  assign Timeout      = timeout_q;
  assign ErrorCount   = err_q;
  assign FirstErrAddr = first_q;

endmodule

// File: tb/tb_oram_traffic_checker.sv
// Scoreboard bench: a memory-model responder echoes written blocks; expected commands and end status are queued per run.
module tb_oram_traffic_checker;

  localparam int NB  = 8;
  localparam int NA  = 12;
  localparam int ST  = 3;
  localparam int GAP = 3;
  localparam int TMO = 50;
  localparam int CH  = 8;

  typedef struct { logic [1:0] op; logic [31:0] addr; } cmd_t;
  typedef struct { logic done; logic pass; logic tmo; logic [15:0] err; logic [31:0] first; } stat_t;

  logic        Clock;
  logic        rst_main, rst_force, rst_w;
  logic        Start;
  logic [1:0]  Mode;
  logic [1:0]  Cmd;
  logic [31:0] PAddr;
  logic        CmdValid, CmdReady;
  logic [31:0] DataIn;
  logic        DataInValid, DataInReady;
  logic [31:0] DataOut;
  logic        DataOutValid, DataOutReady;
  logic        Busy, Done, Pass, Timeout;
  logic [15:0] ErrorCount;
  logic [31:0] FirstErrAddr;

  assign rst_w = rst_main & ~rst_force;

  oram_traffic_checker #(
    .ORAMU(32), .ORAMB(256), .FEDWidth(32), .NumBlocks(NB), .NumAccesses(NA),
    .Stride(ST), .GapCycles(GAP), .TimeoutCycles(TMO)
  ) dut (
    .Clock(Clock), .Reset(rst_w), .Start(Start), .Mode(Mode),
    .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .Busy(Busy), .Done(Done), .Pass(Pass), .Timeout(Timeout),
    .ErrorCount(ErrorCount), .FirstErrAddr(FirstErrAddr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  cmd_t  cq[$];
  stat_t sq[$];

  // Knobs owned by the main sequence
  bit cmd_en = 1'b1, inj_en = 1'b0, spur_arm = 1'b0, rst_arm = 1'b0, addr_chk = 1'b1;

  // Responder state
  logic [31:0] mem [NB][CH];
  bit          tb_exist [NB];
  bit          wr_active, rd_active;
  int          wbeat, rbeat, cur_addr, fired, idle_cnt;
  logic [31:0] wbase;

  initial begin
    bit   live;
    cmd_t e;
    CmdReady = 0; DataInReady = 0; DataOutValid = 0; DataOut = '0; rst_force = 0;
    wr_active = 0; rd_active = 0; wbeat = 0; rbeat = 0; cur_addr = 0; fired = 0; idle_cnt = 0; wbase = '0;
    forever begin
      @(negedge Clock);
      if (!rst_arm) rst_force = 1'b0;
      live = rst_main && !rst_force;
      if (!live) begin wr_active = 0; rd_active = 0; end
      if (!Busy) begin
        fired = 0;
        for (int i = 0; i < NB; i++) tb_exist[i] = 1'b0;
      end
      if (Busy && !CmdValid && !DataInValid && !DataOutReady) idle_cnt++;
      else idle_cnt = 0;

      CmdReady     = cmd_en && ($urandom_range(0, 3) != 0);
      DataInReady  = ($urandom_range(0, 3) != 0);
      DataOutValid = 1'b0;
      DataOut      = '0;
      if (rd_active && $urandom_range(0, 3) != 0) begin
        DataOutValid = 1'b1;
        DataOut = mem[cur_addr][rbeat] ^ ((inj_en && cur_addr == 2 && rbeat == 3) ? 32'd1 : 32'd0);
      end else if (spur_arm && fired == 2 && idle_cnt == 2) begin
        DataOutValid = 1'b1;
        DataOut = $urandom;
        check_eq("spur_not_accepted", DataOutReady, 0);
      end

      if (rst_arm && live && wr_active && DataInValid && wbeat == 5) begin
        rst_force = 1'b1;
        live = 1'b0;
      end

      if (live && CmdValid && CmdReady) begin
        fired++;
        if (addr_chk) begin
          check_eq("cmd_expected", cq.size() != 0, 1);
          if (cq.size() != 0) begin
            e = cq.pop_front();
            check_eq("cmd_op", Cmd, e.op);
            check_eq("cmd_addr", PAddr, e.addr);
          end
        end else begin
          check_eq("cmd_addr_range", PAddr < NB, 1);
          check_eq("cmd_op_model", Cmd, tb_exist[PAddr[2:0]] ? 2 : 0);
        end
        tb_exist[PAddr[2:0]] = 1'b1;
        cur_addr = int'(PAddr[2:0]);
        if (Cmd == 2'd0) begin wr_active = 1; wbeat = 0; end
        else begin rd_active = 1; rbeat = 0; end
      end
      if (live && wr_active && DataInValid && DataInReady) begin
        if (wbeat == 0) wbase = DataIn;
        else check_eq("wbeat_step", DataIn, wbase + 32'(wbeat));
        mem[cur_addr][wbeat] = DataIn;
        wbeat++;
        if (wbeat == CH) wr_active = 0;
      end
      if (live && rd_active && DataOutValid && DataOutReady) begin
        rbeat++;
        if (rbeat == CH) rd_active = 0;
      end
    end
  end

  function automatic int addr_of(input int m, input int i);
    case (m)
      0:       return i % NB;
      1:       return (i * ST) % NB;
      default: return (i < NA / 2) ? i % NB : ((i - NA / 2) * ST) % NB;
    endcase
  endfunction

  task automatic run_test(input int mode, input bit rdy, input bit inj, input bit spur,
                          input bit mid_start, input stat_t exp_s);
    bit    ex [NB];
    bit    got, pulsed;
    int    cv_cnt, a;
    stat_t s;
    cq.delete();
    addr_chk = (mode != 2);
    if (addr_chk) begin
      for (int i = 0; i < NB; i++) ex[i] = 1'b0;
      for (int i = 0; i < NA; i++) begin
        a = addr_of(mode, i);
        cq.push_back('{ex[a] ? 2'd2 : 2'd0, 32'(a)});
        ex[a] = 1'b1;
      end
    end
    sq.push_back(exp_s);
    cmd_en = rdy; inj_en = inj; spur_arm = spur;
    @(negedge Clock); Mode = 2'(mode); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    got = 0; pulsed = 0; cv_cnt = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge Clock);
      if (CmdValid) cv_cnt++;
      if (mid_start && !pulsed && fired == 3) begin Start = 1'b1; pulsed = 1'b1; end
      else Start = 1'b0;
      if (Done) begin got = 1; break; end
    end
    Start = 1'b0;
    check_eq("done_within_budget", got, 1);
    s = sq.pop_front();
    check_eq("done", Done, s.done);
    check_eq("pass", Pass, s.pass);
    check_eq("timeout", Timeout, s.tmo);
    check_eq("busy_clear", Busy, 0);
    check_eq("error_count", ErrorCount, s.err);
    check_eq("first_err_addr", FirstErrAddr, s.first);
    if (rdy && addr_chk) check_eq("cmds_remaining", cq.size(), 0);
    if (!rdy) check_eq("cmd_wait_cycles", cv_cnt, TMO);
    inj_en = 0; spur_arm = 0; cmd_en = 1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, |{Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady, Busy, Done,
                    Pass, Timeout, ErrorCount, FirstErrAddr}, 0);
  endtask

  initial begin
    bit hit;
    rst_main = 1'b0; Start = 1'b0; Mode = 2'd0;
    repeat (3) @(negedge Clock);
    check_outputs_zero("reset_outputs");
    rst_main = 1'b1;
    repeat (2) @(negedge Clock);

    run_test(0, 1, 0, 0, 0, '{1, 1, 0, 16'd0, 32'd0});   // sequential, ideal
    run_test(3, 1, 0, 0, 0, '{1, 1, 0, 16'd0, 32'd0});   // mixed, reads plus late updates
    run_test(1, 1, 0, 0, 1, '{1, 1, 0, 16'd0, 32'd0});   // strided, Start pulsed while busy
    run_test(2, 1, 0, 0, 0, '{1, 1, 0, 16'd0, 32'd0});   // LFSR addressing
    run_test(0, 1, 1, 0, 0, '{1, 0, 0, 16'd1, 32'd2});   // corrupted beat 3 of block 2
    run_test(0, 1, 0, 1, 0, '{1, 0, 0, 16'd1, 32'd2});   // spurious beat in GAP
    run_test(0, 0, 0, 0, 0, '{1, 0, 1, 16'd1, 32'd0});   // CmdReady stuck low

    // Reset in the middle of the first write burst, then a clean rerun
    cq.delete(); addr_chk = 0; rst_arm = 1'b1;
    @(negedge Clock); Mode = 2'd0; Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clock);
      if (rst_force) begin hit = 1; break; end
    end
    check_eq("reset_mid_write_reached", hit, 1);
    @(posedge Clock); #1;
    check_outputs_zero("mid_run_reset_outputs");
    @(negedge Clock); rst_arm = 1'b0;
    repeat (2) @(negedge Clock);
    run_test(0, 1, 0, 0, 0, '{1, 1, 0, 16'd0, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oram_traffic_checker.md
Name: oram_traffic_checker

Overview:
- Synthesizable traffic generator and checker for the PathORamTop frontend interface (Cmd/PAddr, DataIn, DataOut).
- Replaces the behavioural host stimulus with a parametrised engine: selectable address modes, configurable access count and inter-command gap, response timeout, and on-chip pass/fail.
- Sits between a control/status host and the ORAM top for FPGA bring-up and regression.

Parameters:
ORAMU, 32, program address width
ORAMB, 512, block size in bits
FEDWidth, 32, frontend data beat width; Chunks = ORAMB/FEDWidth
NumBlocks, 256, shadow depth; power of two; addresses generated in [0, NumBlocks-1]
NumAccesses, 600, commands issued per run
Stride, 16, address stride for strided modes
GapCycles, 100, idle cycles before each command
TimeoutCycles, 65535, max wait cycles for any handshake

Ports:
Clock  in  1  clock
Reset  in  1  reset
Start  in  1  one-cycle run pulse
Mode  in  2  0 sequential, 1 strided, 2 LFSR, 3 mixed
Cmd  out  2  0 Update, 1 Append, 2 Read, 3 ReadRmv
PAddr  out  ORAMU  block address
CmdValid  out  1  command valid
CmdReady  in  1  command accepted
DataIn  out  FEDWidth  write beat
DataInValid  out  1  write beat valid
DataInReady  in  1  write beat accepted
DataOut  in  FEDWidth  read beat
DataOutValid  in  1  read beat valid
DataOutReady  out  1  read beat accept
Busy  out  1  run in progress
Done  out  1  run finished (sticky until next Start)
Pass  out  1  Done and ErrorCount==0 and no timeout
Timeout  out  1  handshake timeout occurred
ErrorCount  out  16  saturating mismatch and spurious-beat count
FirstErrAddr  out  ORAMU  PAddr of first error

Behaviour:
- Reset: synchronous, active-low, signal Reset; clock Clock. While Reset==0, all outputs are 0, the FSM enters IDLE, and the LFSR loads 32'hACE1_0001. Shadow contents are not touched.
- Shadow RAM: NumBlocks entries of {Exist, Seed[FEDWidth-1:0]}. Beat k of a block = Seed + k (mod 2^FEDWidth).
- IDLE: on Start, latch Mode, clear counters and flags, set Busy=1, go to CLEAR. Start is ignored whenever Busy=1.
- CLEAR: one shadow entry per cycle gets Exist=0; after NumBlocks cycles, go to GAP.
- GAP: count GapCycles, then go to CMD. GapCycles=0 goes straight to CMD.
- CMD:
  - Op = Exist ? Read : Update.
  - Seed = LFSR output for writes.
  - CmdValid=1, holding Cmd and PAddr stable until CmdReady.
  - Fire goes to WDATA for Update, RDATA for Read.
- WDATA: drive beats k=0..Chunks-1. Each beat is held until DataInReady. After the last beat, write shadow {1, Seed} and go to NEXT.
- RDATA:
  - DataOutReady=1.
  - Compare each beat against StoredSeed+k; each mismatch increments ErrorCount.
  - After Chunks beats, go to NEXT.
- NEXT:
  - AccessCount++ and advance the LFSR.
  - Next address i = AccessCount:
    - mode 0: i mod NumBlocks
    - mode 1: (i*Stride) mod NumBlocks
    - mode 2: LFSR[log2(NumBlocks)-1:0]
    - mode 3: i<NumAccesses/2 ? i : ((i-NumAccesses/2)*Stride) mod NumBlocks
  - Go to DONE if AccessCount==NumAccesses, else GAP.
- DONE: Busy=0, Done=1. Pass is valid. Next Start restarts the run.
- Timeout: a wait counter runs in CMD/WDATA/RDATA and resets on each handshake. On reaching TimeoutCycles: Timeout=1, ErrorCount++, go to DONE.
- Spurious beat: DataOutValid in any state other than RDATA counts as an error; the beat is not accepted (DataOutReady=0).
- FirstErrAddr is captured only on the first error of a run.
- ErrorCount saturates at 16'hFFFF.
- Read of beat and compare occur in the same cycle: zero added latency. Command issue occurs in the cycle after GAP ends.

Optional Feature:
- Macro ORAM_TG_READRMV_EN.
- Defined:
  - For an existing block, LFSR bit 0 selects ReadRmv (1) or Read (0).
  - ReadRmv checks data identically, then writes shadow Exist=0.
  - The next access to that address issues Update.
- Undefined: Cmd is only ever 0 or 2; bit-0 logic is absent.

Test Plan:
- Mode 0, NumAccesses=8, NumBlocks=4, ideal responder echoing stored data -> Cmds U,U,U,U,R,R,R,R on PAddr 0..3,0..3; Done=1, Pass=1, ErrorCount=0.
- Mode 3, NumAccesses=600, Stride=16, NumBlocks=512 -> first 300 Updates to addresses 0..299; then Reads at 0,16,32,...,(i*16)%512, with Updates for addresses not yet written; Pass=1.
- Responder flips bit 0 of beat 3 on the read of address 2 -> ErrorCount=1, FirstErrAddr=2, Pass=0.
- CmdReady held 0, TimeoutCycles=50 -> Timeout=1 after 50 cycles in CMD; Done=1, Pass=0.
- DataOutValid pulsed during GAP -> ErrorCount increments by 1; DataOutReady stays 0.
- Reset driven 0 mid-WDATA beat 5 -> next cycle all outputs 0, FSM IDLE; a subsequent Start runs cleanly to Pass=1.
